// File: rtl/ads_frame_reader.sv
// Read-frame controller for the ADC serial data port: syncs drdy_n, drives cs_n/sclk/s2p_en, flags words.
// Optional STATUS_CHECK_EN macro builds the status-header check driving status_err.
module ads_frame_reader #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned WORD_BITS = 24,
  parameter int unsigned N_WORDS   = 9,
  parameter int unsigned CS_SETUP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        drdy_n,
  input  logic [23:0] parallel_in,
  output logic        cs_n,
  output logic        sclk,
  output logic        s2p_en,
  output logic        word_valid,
  output logic [3:0]  word_idx,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun,
  output logic        status_err
);

  localparam int unsigned HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WORD_BITS + 1);
  localparam int unsigned SU_W  = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;

  state_e             state_q;
  logic               drdy_meta_q, drdy_sync_q, drdy_prev_q;
  logic [HC_W-1:0]    hc_q;
  logic [BIT_W-1:0]   bit_q;
  logic [SU_W-1:0]    setup_q;
  logic [IDX_W-1:0]   word_q;
  logic               cs_n_q, sclk_q, s2p_en_q, busy_q;
  logic               word_valid_q, frame_done_q, overrun_q;
  logic [IDX_W-1:0]   word_idx_q;
  logic               fall_c;
  logic               abort_c;

  assign fall_c  = drdy_prev_q & ~drdy_sync_q;
  assign abort_c = ((state_q == SETUP) || (state_q == SHIFT)) && !en;

  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign s2p_en     = s2p_en_q;
  assign busy       = busy_q;
  assign word_valid = word_valid_q;
  assign word_idx   = word_idx_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

`ifdef STATUS_CHECK_EN
  logic status_err_q;
  logic unused_low_bits_c;
  assign unused_low_bits_c = ^parallel_in[19:0];
  assign status_err        = status_err_q;
`else
  logic unused_parallel_c;
  assign unused_parallel_c = ^parallel_in;
  assign status_err        = 1'b0;
`endif

  // Frame sequencer; every output is registered so sclk/cs_n are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      drdy_meta_q  <= 1'b1;
      drdy_sync_q  <= 1'b1;
      drdy_prev_q  <= 1'b1;
      hc_q         <= '0;
      bit_q        <= '0;
      setup_q      <= '0;
      word_q       <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      s2p_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      word_idx_q   <= '0;
`ifdef STATUS_CHECK_EN
      status_err_q <= 1'b0;
`endif
    end else begin
      drdy_meta_q  <= drdy_n;
      drdy_sync_q  <= drdy_meta_q;
      drdy_prev_q  <= drdy_sync_q;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;

      // An edge while a frame runs is reported but never queued.
      if (fall_c && busy_q && en) begin
        overrun_q <= 1'b1;
      end

`ifdef STATUS_CHECK_EN
      if (word_valid_q && (word_idx_q == '0) && (parallel_in[23:20] != 4'hC)) begin
        status_err_q <= 1'b1;
      end
`endif

      if (abort_c) begin
        state_q  <= IDLE;
        cs_n_q   <= 1'b1;
        sclk_q   <= 1'b0;
        s2p_en_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fall_c && en) begin
              state_q  <= SETUP;
              cs_n_q   <= 1'b0;
              sclk_q   <= 1'b0;
              s2p_en_q <= 1'b1;
              busy_q   <= 1'b1;
              setup_q  <= '0;
              hc_q     <= '0;
              bit_q    <= '0;
              word_q   <= '0;
`ifdef STATUS_CHECK_EN
              status_err_q <= 1'b0;
`endif
            end
          end
          SETUP: begin
            if (setup_q == SU_W'(CS_SETUP - 1)) begin
              state_q <= SHIFT;
            end else begin
              setup_q <= setup_q + SU_W'(1);
            end
          end
          SHIFT: begin
            if (hc_q == HC_W'(CLK_DIV - 1)) begin
              hc_q   <= '0;
              sclk_q <= ~sclk_q;
              if (!sclk_q) begin
                bit_q <= bit_q + BIT_W'(1);
              end else if (bit_q == BIT_W'(WORD_BITS)) begin
                // Falling edge after the last bit: word complete, next word starts without a gap.
                bit_q        <= '0;
                word_q       <= word_q + IDX_W'(1);
                word_valid_q <= 1'b1;
                word_idx_q   <= word_q;
                if (word_q == IDX_W'(N_WORDS - 1)) begin
                  state_q      <= DONE;
                  cs_n_q       <= 1'b1;
                  s2p_en_q     <= 1'b0;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
                end
              end
            end else begin
              hc_q <= hc_q + HC_W'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ads_frame_reader.sv
// Directed self-checking bench for ads_frame_reader with an ADC + s2p behavioural model.
module tb_ads_frame_reader;

  localparam int CLK_DIV   = 2;
  localparam int WORD_BITS = 24;
  localparam int N_WORDS   = 9;
  localparam int CS_SETUP  = 4;
  localparam int WORD_CLK  = 2 * CLK_DIV * WORD_BITS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        drdy_n = 1'b1;
  logic [23:0] parallel_in = '0;
  logic        cs_n, sclk, s2p_en, word_valid, frame_done, busy, overrun, status_err;
  logic [3:0]  word_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ads_frame_reader #(
    .CLK_DIV(CLK_DIV), .WORD_BITS(WORD_BITS), .N_WORDS(N_WORDS), .CS_SETUP(CS_SETUP)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .drdy_n(drdy_n), .parallel_in(parallel_in),
    .cs_n(cs_n), .sclk(sclk), .s2p_en(s2p_en), .word_valid(word_valid),
    .word_idx(word_idx), .frame_done(frame_done), .busy(busy), .overrun(overrun),
    .status_err(status_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC words for the next frame; the s2p model shifts them in MSB first.
  logic [23:0] words [0:8];
  int tb_word = 0;
  int tb_bit = 0;
  int last_frame = 0;

  // Monitor (sole writer of the counters below), sampled on the falling clk edge.
  int wv_count = 0, fd_count = 0, ov_count = 0, cs_falls = 0, sclk_viol = 0;
  int cs_fall_cyc = 0, fd_cyc = 0;
  int cap_idx [0:127];
  logic [23:0] cap_data [0:127];
  int cap_cyc [0:127];
  logic cs_prev = 1'b1;

  always @(posedge sclk) begin
    logic [23:0] w;
    if (cs_falls != last_frame) begin
      last_frame = cs_falls;
      tb_word = 0;
      tb_bit = 0;
    end
    if (s2p_en) begin
      w = (tb_word < N_WORDS) ? words[tb_word] : 24'h0;
      parallel_in <= {parallel_in[22:0], w[23 - tb_bit]};
      if (tb_bit == WORD_BITS - 1) begin
        tb_bit = 0;
        tb_word = tb_word + 1;
      end else begin
        tb_bit = tb_bit + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (word_valid) begin
      if (wv_count < 128) begin
        cap_idx[wv_count]  = int'(word_idx);
        cap_data[wv_count] = parallel_in;
        cap_cyc[wv_count]  = cyc;
      end
      wv_count = wv_count + 1;
    end
    if (frame_done) begin
      fd_count = fd_count + 1;
      fd_cyc = cyc;
    end
    if (overrun) ov_count = ov_count + 1;
    if (cs_prev && !cs_n) begin
      cs_falls = cs_falls + 1;
      cs_fall_cyc = cyc;
    end
    if (cs_n && sclk) sclk_viol = sclk_viol + 1;
    cs_prev = cs_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_words(input logic [23:0] base);
    for (int k = 0; k < N_WORDS; k++) words[k] = base + 24'(k);
  endtask

  task automatic pulse_drdy(output int dc);
    @(posedge clk); #1;
    drdy_n = 1'b0;
    dc = cyc;
    repeat (4) @(posedge clk);
    #1 drdy_n = 1'b1;
  endtask

  task automatic wait_words(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (wv_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (fd_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; drdy_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cs_n !== 1'b1)   begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    checks++; if (sclk !== 1'b0)   begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (s2p_en !== 1'b0) begin errors++; $display("FAIL reset_s2p_en: got %b expected 0", s2p_en); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (word_idx !== 4'd0) begin errors++; $display("FAIL reset_word_idx: got %0d expected 0", word_idx); end
    checks++; if ({word_valid, frame_done, overrun, status_err} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {word_valid, frame_done, overrun, status_err});
    end
    reset = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame();
    int dc, w0, f0, c0;
    bit ok;
    w0 = wv_count; f0 = fd_count;
    set_words(24'hC00000);
    pulse_drdy(dc);
    c0 = cs_fall_cyc;
    checks++; if (c0 - dc != 3) begin errors++; $display("FAIL frame_cs_latency: got %0d expected 3", c0 - dc); end
    wait_done(f0 + 1, 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_done_timeout: got none expected frame_done"); end
    checks++; if (wv_count - w0 != N_WORDS) begin errors++; $display("FAIL frame_word_count: got %0d expected %0d", wv_count - w0, N_WORDS); end
    for (int k = 0; k < N_WORDS; k++) begin
      checks++; if (cap_idx[w0 + k] != k) begin errors++; $display("FAIL frame_idx[%0d]: got %0d expected %0d", k, cap_idx[w0 + k], k); end
      checks++; if (cap_data[w0 + k] !== words[k]) begin errors++; $display("FAIL frame_data[%0d]: got %h expected %h", k, cap_data[w0 + k], words[k]); end
      checks++; if (cap_cyc[w0 + k] != c0 + CS_SETUP + WORD_CLK * (k + 1)) begin
        errors++; $display("FAIL frame_word_time[%0d]: got %0d expected %0d", k, cap_cyc[w0 + k] - c0, CS_SETUP + WORD_CLK * (k + 1));
      end
    end
    checks++; if (fd_cyc - c0 != CS_SETUP + N_WORDS * WORD_CLK) begin
      errors++; $display("FAIL frame_done_time: got %0d expected %0d", fd_cyc - c0, CS_SETUP + N_WORDS * WORD_CLK);
    end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || cs_n !== 1'b1 || s2p_en !== 1'b0) begin
      errors++; $display("FAIL frame_end_state: got busy=%b cs_n=%b s2p_en=%b expected 0 1 0", busy, cs_n, s2p_en);
    end
    checks++; if (fd_count - f0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_count - f0); end
    checks++; if (sclk_viol != 0) begin errors++; $display("FAIL sclk_while_cs_high: got %0d expected 0", sclk_viol); end
  endtask

  task automatic test_overrun();
    int dc, w0, f0, o0, s0;
    bit ok;
    w0 = wv_count; f0 = fd_count; o0 = ov_count; s0 = cs_falls;
    set_words(24'hC00100);
    pulse_drdy(dc);
    wait_words(w0 + 4, 600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_word4_timeout: got none expected word 3"); end
    pulse_drdy(dc);
    wait_done(f0 + 1, 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_done_timeout: got none expected frame_done"); end
    checks++; if (ov_count - o0 != 1) begin errors++; $display("FAIL overrun_pulses: got %0d expected 1", ov_count - o0); end
    checks++; if (wv_count - w0 != N_WORDS) begin errors++; $display("FAIL overrun_word_count: got %0d expected %0d", wv_count - w0, N_WORDS); end
    checks++; if (cap_idx[w0 + 8] != 8) begin errors++; $display("FAIL overrun_last_idx: got %0d expected 8", cap_idx[w0 + 8]); end
    checks++; if (cap_data[w0 + 4] !== words[4]) begin errors++; $display("FAIL overrun_word4_data: got %h expected %h", cap_data[w0 + 4], words[4]); end
    repeat (30) @(negedge clk);
    checks++; if (fd_count - f0 != 1) begin errors++; $display("FAIL overrun_done_count: got %0d expected 1", fd_count - f0); end
    checks++; if (cs_falls - s0 != 1) begin errors++; $display("FAIL overrun_queued_frame: got %0d cs falls expected 1", cs_falls - s0); end
  endtask

  task automatic test_abort();
    int dc, w0, f0;
    bit ok;
    w0 = wv_count; f0 = fd_count;
    set_words(24'hC00200);
    pulse_drdy(dc);
    wait_words(w0 + 3, 600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_word2_timeout: got none expected word 2"); end
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cs_n !== 1'b1 || busy !== 1'b0 || sclk !== 1'b0 || s2p_en !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: got cs_n=%b busy=%b sclk=%b s2p_en=%b expected 1 0 0 0", cs_n, busy, sclk, s2p_en);
    end
    repeat (300) @(negedge clk);
    checks++; if (wv_count - w0 != 3) begin errors++; $display("FAIL abort_words_after: got %0d expected 3", wv_count - w0); end
    checks++; if (fd_count != f0) begin errors++; $display("FAIL abort_frame_done: got %0d expected 0", fd_count - f0); end
    en = 1'b1;
    w0 = wv_count;
    set_words(24'hC00300);
    pulse_drdy(dc);
    wait_done(f0 + 1, 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout: got none expected frame_done"); end
    checks++; if (cap_idx[w0] != 0) begin errors++; $display("FAIL abort_restart_idx0: got %0d expected 0", cap_idx[w0]); end
    checks++; if (cap_data[w0] !== 24'hC00300) begin errors++; $display("FAIL abort_restart_data0: got %h expected c00300", cap_data[w0]); end
    checks++; if (cap_data[w0 + 8] !== 24'hC00308) begin errors++; $display("FAIL abort_restart_data8: got %h expected c00308", cap_data[w0 + 8]); end
  endtask

  task automatic test_reset_mid();
    int dc, w0, f0, s0;
    bit ok;
    bit hi;
    w0 = wv_count;
    set_words(24'hC00400);
    pulse_drdy(dc);
    wait_words(w0 + 1, 300, ok);
    hi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sclk) begin hi = 1'b1; break; end
    end
    checks++; if (!hi) begin errors++; $display("FAIL reset_mid_sclk_high: got sclk low expected high"); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || s2p_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: got cs_n=%b sclk=%b s2p_en=%b busy=%b expected 1 0 0 0", cs_n, sclk, s2p_en, busy);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (cs_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got cs_n=%b busy=%b expected 1 0", cs_n, busy); end
    w0 = wv_count; f0 = fd_count; s0 = cs_falls;
    pulse_drdy(dc);
    checks++; if (cs_falls - s0 != 1 || cs_fall_cyc - dc != 3) begin
      errors++; $display("FAIL reset_mid_restart: got falls=%0d latency=%0d expected 1 3", cs_falls - s0, cs_fall_cyc - dc);
    end
    wait_done(f0 + 1, 1200, ok);
    checks++; if (!ok || wv_count - w0 != N_WORDS || cap_idx[w0] != 0) begin
      errors++; $display("FAIL reset_mid_frame: got words=%0d idx0=%0d expected %0d 0", wv_count - w0, cap_idx[w0], N_WORDS);
    end
  endtask

  task automatic test_status();
    int dc, f0;
    bit ok;
    f0 = fd_count;
    set_words(24'hC00000);
    words[0] = 24'h800000;
    pulse_drdy(dc);
    wait_done(f0 + 1, 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL status_frame_timeout: got none expected frame_done"); end
`ifdef STATUS_CHECK_EN
    checks++; if (status_err !== 1'b1) begin errors++; $display("FAIL status_err_set: got %b expected 1", status_err); end
    set_words(24'hC00000);
    pulse_drdy(dc);
    checks++; if (status_err !== 1'b0) begin errors++; $display("FAIL status_err_clear_on_start: got %b expected 0", status_err); end
    wait_done(f0 + 2, 1200, ok);
    checks++; if (!ok || status_err !== 1'b0) begin errors++; $display("FAIL status_err_good_frame: got %b expected 0", status_err); end
`else
    checks++; if (status_err !== 1'b0) begin errors++; $display("FAIL status_err_tied: got %b expected 0", status_err); end
`endif
  endtask

  task automatic test_en_low_edge();
    int dc, s0, o0;
    s0 = cs_falls; o0 = ov_count;
    en = 1'b0;
    pulse_drdy(dc);
    repeat (20) @(negedge clk);
    checks++; if (cs_falls != s0) begin errors++; $display("FAIL en_low_cs_activity: got %0d falls expected 0", cs_falls - s0); end
    checks++; if (ov_count != o0) begin errors++; $display("FAIL en_low_overrun: got %0d expected 0", ov_count - o0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_low_busy: got %b expected 0", busy); end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_status();
    test_en_low_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
